// File: rtl/fdc_pkg.sv
// Shared types and constants for the frequency-to-digital counter.
// Imported by fdc_edge_sync and fdc_counter.
package fdc_pkg;

    // Synchronizer stages ahead of the rise-detect history flop
    localparam int SYNC_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        GATE = 2'd2,
        DONE = 2'd3
    } fdc_state_t;

endpackage

// File: rtl/fdc_counter_if.sv
// Measurement request / result handshake bundle of fdc_counter.
// slave = counter side, master = requester/consumer side.
interface fdc_counter_if #(
    parameter int NBIT = 13
);
    logic                   start;
    logic                   busy;
    logic                   out_valid;
    logic                   out_ready;
    logic [NBIT-1:0]        code;
    logic signed [NBIT:0]   err;
    logic                   ovf;
    logic                   no_sig;

    modport slave (
        input  start,
        input  out_ready,
        output busy,
        output out_valid,
        output code,
        output err,
        output ovf,
        output no_sig
    );

    modport master (
        output start,
        output out_ready,
        input  busy,
        input  out_valid,
        input  code,
        input  err,
        input  ovf,
        input  no_sig
    );
endinterface

// File: rtl/fdc_edge_sync.sv
// Brings the asynchronous oscillator into the clk domain and flags each
// rising edge as a one-cycle pulse (2 to 3 cycles after the real edge).
module fdc_edge_sync
    import fdc_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic sig_in,
    output logic rise
);
    logic [SYNC_DEPTH-1:0] sync_q, sync_d;
    logic                  hist_q, hist_d;

    always_comb begin
        sync_d = {sync_q[SYNC_DEPTH-2:0], sig_in};
        hist_d = sync_q[SYNC_DEPTH-1];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign rise = sync_q[SYNC_DEPTH-1] & ~hist_q;

endmodule

// File: rtl/fdc_counter.sv
// Gated edge counter: counts oscillator rising edges over a fixed clk window.
// Define FDC_AUTORUN_EN to re-arm automatically after each accepted result.
module fdc_counter
    import fdc_pkg::*;
#(
    parameter int GATE_CYCLES = 1024,
    parameter int NBIT        = 13,
    parameter int CODE_CENTER = 4096
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          sig_in,
    fdc_counter_if.slave  bus
);
    localparam int              TW       = $clog2(GATE_CYCLES) + 1;
    localparam logic [TW-1:0]   TMR_LAST = TW'(GATE_CYCLES - 1);
    localparam logic [NBIT-1:0] CNT_MAX  = '1;
    localparam logic [NBIT:0]   CENTER   = (NBIT+1)'(CODE_CENTER);

    function automatic logic [NBIT-1:0] sat_inc(input logic [NBIT-1:0] v);
        return (v == CNT_MAX) ? v : v + NBIT'(1);
    endfunction

    // Plain modular difference; the result wraps if CODE_CENTER is out of range
    function automatic logic signed [NBIT:0] calc_err(input logic [NBIT-1:0] c);
        return $signed({1'b0, c}) - $signed(CENTER);
    endfunction

    logic rise;

    fdc_edge_sync u_sync (
        .clk    (clk),
        .rstn   (rstn),
        .sig_in (sig_in),
        .rise   (rise)
    );

    fdc_state_t             state_q, state_d;
    logic [NBIT-1:0]        cnt_q, cnt_d;
    logic [TW-1:0]          tmr_q, tmr_d;
    logic                   ovf_acc_q, ovf_acc_d;
    logic                   nosig_acc_q, nosig_acc_d;
    logic                   busy_q, busy_d;
    logic                   out_valid_q, out_valid_d;
    logic [NBIT-1:0]        code_q, code_d;
    logic signed [NBIT:0]   err_q, err_d;
    logic                   ovf_q, ovf_d;
    logic                   no_sig_q, no_sig_d;
    logic                   arm_clr;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmr_d       = tmr_q;
        ovf_acc_d   = ovf_acc_q;
        nosig_acc_d = nosig_acc_q;
        out_valid_d = out_valid_q;
        code_d      = code_q;
        err_d       = err_q;
        ovf_d       = ovf_q;
        no_sig_d    = no_sig_q;
        arm_clr     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ARM;
                    arm_clr = 1'b1;
                end
            end
            ARM: begin
                // The arming edge only opens the window; it is not counted
                if (rise) begin
                    state_d = GATE;
                    tmr_d   = '0;
                end else if (tmr_q == TMR_LAST) begin
                    state_d     = DONE;
                    nosig_acc_d = 1'b1;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            GATE: begin
                if (rise) begin
                    if (cnt_q == CNT_MAX) ovf_acc_d = 1'b1;
                    cnt_d = sat_inc(cnt_q);
                end
                if (tmr_q == TMR_LAST) state_d = DONE;
                else                   tmr_d   = tmr_q + TW'(1);
            end
            DONE: begin
                // First DONE cycle captures the result; later cycles wait for the consumer
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    code_d      = cnt_q;
                    err_d       = calc_err(cnt_q);
                    ovf_d       = ovf_acc_q;
                    no_sig_d    = nosig_acc_q;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
`ifdef FDC_AUTORUN_EN
                    state_d = ARM;
                    arm_clr = 1'b1;
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        if (arm_clr) begin
            cnt_d       = '0;
            tmr_d       = '0;
            ovf_acc_d   = 1'b0;
            nosig_acc_d = 1'b0;
        end

        busy_d = (state_d == ARM) || (state_d == GATE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tmr_q       <= '0;
            ovf_acc_q   <= 1'b0;
            nosig_acc_q <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            code_q      <= '0;
            err_q       <= '0;
            ovf_q       <= 1'b0;
            no_sig_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmr_q       <= tmr_d;
            ovf_acc_q   <= ovf_acc_d;
            nosig_acc_q <= nosig_acc_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            code_q      <= code_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
            no_sig_q    <= no_sig_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.code      = code_q;
    assign bus.err       = err_q;
    assign bus.ovf       = ovf_q;
    assign bus.no_sig    = no_sig_q;

endmodule

// File: tb/tb_fdc_counter.sv
// Randomized bench for fdc_counter with a count-from-period reference model.
// Build with FDC_AUTORUN_EN defined to exercise the auto-rerun mode instead.
module tb_fdc_counter;
    localparam int G    = 64;
    localparam int NB   = 4;
    localparam int CC   = 9;
    localparam int MAXC = (1 << NB) - 1;

    logic clk    = 1'b0;
    logic rstn   = 1'b0;
    logic sig_in = 1'b0;

    always #5 clk = ~clk;

    fdc_counter_if #(.NBIT(NB)) bus ();

    fdc_counter #(
        .GATE_CYCLES (G),
        .NBIT        (NB),
        .CODE_CENTER (CC)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .sig_in (sig_in),
        .bus    (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Periodic oscillator, changing on the falling clk edge
    int per    = 8;
    int hi     = 4;
    int sig_on = 0;
    int ph     = 0;

    initial forever begin
        @(negedge clk);
        if (sig_on == 0) begin
            sig_in = 1'b0;
            ph     = 0;
        end else begin
            ph     = (ph + 1 >= per) ? 0 : ph + 1;
            sig_in = (ph < hi);
        end
    end

    // A window of G cycles after the arming edge holds floor(G/p) rising edges
    task automatic model(input int p, input int on, output int c, output int o,
                         output int ns, output logic [NB:0] e);
        int n;
        if (on == 0) begin
            c = 0; o = 0; ns = 1;
        end else begin
            n  = G / p;
            c  = (n > MAXC) ? MAXC : n;
            o  = (n > MAXC) ? 1 : 0;
            ns = 0;
        end
        e = (NB+1)'(c - CC);
    endtask

    task automatic kick(input int p, input int h, input int on, input logic ready);
        per = p; hi = h; sig_on = on;
        repeat (3) @(negedge clk);
        bus.out_ready = ready;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_on_start", bus.busy, 1);
    endtask

    task automatic finish_meas(input int p, input int on, input int stall);
        int cyc;
        int ec, eo, ens;
        logic [NB:0] ee;
        model(p, on, ec, eo, ens, ee);
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk("out_valid_seen", bus.out_valid, 1);
        chk("busy_in_done", bus.busy, 0);
        chk("code", bus.code, ec);
        chk("ovf", bus.ovf, eo);
        chk("no_sig", bus.no_sig, ens);
        chk("err", $unsigned(bus.err), ee);
        if (stall == 0) begin
            @(negedge clk);
            chk("valid_drop", bus.out_valid, 0);
        end else begin
            for (int i = 0; i < stall; i++) begin
                bus.start = i[0];
                @(negedge clk);
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_code", bus.code, ec);
                chk("stall_err", $unsigned(bus.err), ee);
                chk("stall_busy", bus.busy, 0);
            end
            bus.out_ready = 1'b1;
            bus.start     = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            chk("valid_drop", bus.out_valid, 0);
            @(negedge clk);
            chk("start_at_accept_ignored", bus.busy, 0);
        end
        chk("code_hold", bus.code, ec);
        chk("no_sig_hold", bus.no_sig, ens);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p, h, arm_len, seen;
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        rstn          = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_code", bus.code, 0);
        chk("rst_err", $unsigned(bus.err), 0);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_no_sig", bus.no_sig, 0);
        rstn = 1'b1;

`ifdef FDC_AUTORUN_EN
        kick(8, 4, 1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            finish_meas(8, 1, 0);
            bus.out_ready = 1'b1;
            chk("autorun_rearm", bus.busy, 1);
        end
`else
        kick(8, 4, 1, 1'b1);
        finish_meas(8, 1, 0);

        kick(2, 1, 1, 1'b0);
        finish_meas(2, 1, 3);

        kick(4, 1, 1, 1'b1);
        finish_meas(4, 1, 0);

        kick(8, 4, 0, 1'b1);
        arm_len = 1;
        while (bus.busy === 1'b1 && arm_len < 300) begin
            @(negedge clk);
            if (bus.busy === 1'b1) arm_len++;
        end
        chk("arm_timeout_len", arm_len, G);
        finish_meas(8, 0, 0);

        kick(8, 3, 1, 1'b0);
        finish_meas(8, 1, 10);

        for (int k = 0; k < 12; k++) begin
            p = $urandom_range(20, 2);
            h = $urandom_range(p - 1, 1);
            if ($urandom_range(1, 0) == 1) begin
                kick(p, h, 1, 1'b1);
                finish_meas(p, 1, 0);
            end else begin
                kick(p, h, 1, 1'b0);
                finish_meas(p, 1, $urandom_range(4, 1));
            end
        end

        // Abandon a measurement with an asynchronous reset mid-window
        kick(4, 2, 1, 1'b0);
        repeat (20) @(negedge clk);
        chk("busy_mid_gate", bus.busy, 1);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_code", bus.code, 0);
        chk("arst_err", $unsigned(bus.err), 0);
        chk("arst_ovf", bus.ovf, 0);
        chk("arst_no_sig", bus.no_sig, 0);
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        repeat (150) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1 || bus.busy === 1'b1) seen = 1;
        end
        chk("no_result_after_reset", seen, 0);

        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn          = 1'b1;
        bus.start     = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_after_reset", bus.busy, 1);
        finish_meas(4, 1, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fdc_counter.md
FDC_COUNTER -- requirements
Module: fdc_counter

Interface
REQ-001 Parameter GATE_CYCLES, default 1024: gate window length in clk cycles; legal values are 2 and above.
REQ-002 Parameter NBIT, default 13: result code width in bits.
REQ-003 Parameter CODE_CENTER, default 4096: expected count, used for the signed error output.
REQ-004 Port clk, input, 1: sampling/reference clock; all state is on its rising edge.
REQ-005 Port rstn, input, 1: reset, asynchronous and active-low.
REQ-006 Port sig_in, input, 1: oscillator output under measurement; asynchronous to clk; frequency below fclk/2.
REQ-007 Port start, input, 1: request one measurement; single-cycle pulse or level.
REQ-008 Port busy, output, 1: high in states ARM and GATE.
REQ-009 Port out_valid, output, 1: result available.
REQ-010 Port out_ready, input, 1: consumer accepts the result.
REQ-011 Port code, output, NBIT: rising-edge count of sig_in within the gate, saturated.
REQ-012 Port err, output, NBIT+1: signed value code minus CODE_CENTER.
REQ-013 Port ovf, output, 1: count saturated during the window.
REQ-014 Port no_sig, output, 1: no arming edge seen before timeout.

Function
REQ-015 sig_in SHALL pass a 2-flop synchronizer plus 1 history flop; rise = sync2 & ~hist; edge-to-rise latency is 2 to 3 clk cycles.
REQ-016 FSM states SHALL be IDLE, ARM, GATE, DONE; the reset state is IDLE.
REQ-017 IDLE -> ARM on start=1; the edge counter, timer, ovf and no_sig clear on this transition.
REQ-018 ARM -> GATE on the first rise; this arming edge SHALL NOT be counted.
REQ-019 If no rise occurs within GATE_CYCLES cycles in ARM, the FSM SHALL go ARM -> DONE with code=0 and no_sig=1.
REQ-020 The GATE window SHALL be exactly GATE_CYCLES cycles; each rise in the window increments the counter, including a rise on the last window cycle.
REQ-021 Timer SHALL be sized $clog2(GATE_CYCLES)+1 bits; GATE -> DONE when timer == GATE_CYCLES-1.
REQ-022 Edge counter SHALL be NBIT bits and saturate at 2^NBIT-1; an increment attempted at saturation sets ovf=1.
REQ-023 On entry to DONE, code, err, ovf and no_sig SHALL be registered and out_valid=1 on the following cycle; outputs stay stable while out_valid=1.
REQ-024 err SHALL be computed as sign-extended {1'b0,code} minus CODE_CENTER in NBIT+1 bits; no saturation is applied.
REQ-025 DONE -> IDLE on out_valid & out_ready; out_valid drops the next cycle; code, err, ovf and no_sig hold their last values.
REQ-026 start SHALL be ignored in ARM, GATE and DONE; start arriving in the same cycle as the DONE acceptance is ignored.
REQ-027 out_ready held high before DONE SHALL be permitted; acceptance occurs on the first out_valid cycle.

Reset
REQ-028 When rstn=0, state SHALL be IDLE, synchronizer/counter/timer cleared, and busy, out_valid, code, err, ovf, no_sig = 0 immediately, independent of clk.
REQ-029 Reset mid-measurement SHALL abandon the measurement and produce no result.
REQ-030 Deassertion SHALL be treated as synchronous to clk; the first start is accepted on the first edge after deassertion.

Configuration
REQ-031 With macro FDC_AUTORUN_EN defined, DONE SHALL exit to ARM instead of IDLE on acceptance; continuous measurement then runs after one start until reset.
REQ-032 Without FDC_AUTORUN_EN, the block SHALL be single-shot per REQ-025.

Structure
REQ-033 Package fdc_pkg SHALL hold the FSM state enum fdc_state_t and a localparam for the synchronizer depth (2).
REQ-034 Sub-module fdc_edge_sync SHALL contain the synchronizer and rise detector; all other logic is in fdc_counter.

Verification
REQ-035 Scenario: GATE_CYCLES=64, sig_in period 8 clk, start pulse -> out_valid with code=8, err=8-CODE_CENTER, ovf=0, no_sig=0.
REQ-036 Scenario: NBIT=4, GATE_CYCLES=64, sig_in period 2 clk -> code=15, ovf=1.
REQ-037 Scenario: sig_in constant 0, GATE_CYCLES=64 -> DONE 64 cycles after ARM entry, code=0, no_sig=1.
REQ-038 Scenario: out_ready=0 for 10 cycles after out_valid, extra start pulses -> outputs stable, start ignored, IDLE after ready.
REQ-039 Scenario: rstn pulsed low mid-GATE -> all outputs 0 that cycle, IDLE, no out_valid.
REQ-040 Scenario: FDC_AUTORUN_EN defined, out_ready=1, period 8 -> repeated results of code=8 without further start.
